// File: rtl/imm_ext_arbiter.sv
// Shared immediate sign-extension stage for the SPU even- and odd-pipe decoders.
// A round-robin arbiter accepts one request per cycle. The chosen field is extended
// to DATA_W bits, or extended to 32 bits and splatted, and the result is held in an
// output register behind a valid/ready handshake.
module imm_ext_arbiter #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [17:0]       req_imm0,
  input  logic [17:0]       req_imm1,
  input  logic [1:0]        req_fmt0,
  input  logic [1:0]        req_fmt1,
  input  logic              req_splat0,
  input  logic              req_splat1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tag,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e              state_q, state_d;
  logic                rr_ptr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_tag_q;
  logic [CNT_W-1:0]    cnt0_q, cnt1_q;

  logic                can_load;
  logic                grant;
  logic                win;
  logic [DATA_W-1:0]   win_data;

  // Sign-extend the selected field width; bits above it never reach the result.
  function automatic logic [DATA_W-1:0] extend(input logic [17:0] imm, input logic [1:0] fmt,
                                               input logic splat);
    logic [31:0]       word;
    logic [DATA_W-1:0] wide;
    case (fmt)
      2'b00: begin
        word = {{25{imm[6]}}, imm[6:0]};
        wide = {{(DATA_W-7){imm[6]}}, imm[6:0]};
      end
      2'b01: begin
        word = {{22{imm[9]}}, imm[9:0]};
        wide = {{(DATA_W-10){imm[9]}}, imm[9:0]};
      end
      2'b10: begin
        word = {{16{imm[15]}}, imm[15:0]};
        wide = {{(DATA_W-16){imm[15]}}, imm[15:0]};
      end
      default: begin
        word = {{14{imm[17]}}, imm[17:0]};
        wide = {{(DATA_W-18){imm[17]}}, imm[17:0]};
      end
    endcase
    return splat ? {(DATA_W/32){word}} : wide;
  endfunction

  // A new result may enter when the register is empty or is being drained this cycle.
  assign can_load = (state_q == StEmpty) || (out_valid && out_ready);

  // Round-robin arbitration; no grants while reset is asserted.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (reset && can_load) begin
      case (req_valid)
        2'b01:   begin grant = 1'b1; win = 1'b0;     end
        2'b10:   begin grant = 1'b1; win = 1'b1;     end
        2'b11:   begin grant = 1'b1; win = rr_ptr_q; end
        default: begin grant = 1'b0; win = 1'b0;     end
      endcase
    end
    req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    win_data  = win ? extend(req_imm1, req_fmt1, req_splat1)
                    : extend(req_imm0, req_fmt0, req_splat0);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Next state: a grant always fills; a drain without a grant empties.
  always_comb begin
    state_d = state_q;
    if (grant)                                    state_d = StFull;
    else if (state_q == StFull && out_ready)      state_d = StEmpty;
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    out_valid  = (state_q == StFull);
    out_data   = out_data_q;
    out_tag    = out_tag_q;
    grant_cnt0 = cnt0_q;
    grant_cnt1 = cnt1_q;
  end

  // Result register, round-robin pointer and saturating grant counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q <= '0;
      out_tag_q  <= 1'b0;
      rr_ptr_q   <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (grant) begin
      out_data_q <= win_data;
      out_tag_q  <= win;
      rr_ptr_q   <= ~win;
      if (win) begin
        if (cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        if (cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: a behavioural model predicts grants and
// results, a separate monitor checks each result as the consumer accepts it.
module tb_imm_ext_arbiter;

  localparam int DW = 128;
  localparam int CW = 4;  // narrow counters so saturation is reached

  typedef struct {
    logic          tag;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [17:0]   req_imm0 = '0, req_imm1 = '0;
  logic [1:0]    req_fmt0 = '0, req_fmt1 = '0;
  logic          req_splat0 = 1'b0, req_splat1 = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_tag;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Model state
  logic m_full = 1'b0;
  logic m_ptr  = 1'b0;
  int   m_cnt[2] = '{0, 0};

  imm_ext_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_imm0   (req_imm0),
    .req_imm1   (req_imm1),
    .req_fmt0   (req_fmt0),
    .req_fmt1   (req_fmt1),
    .req_splat0 (req_splat0),
    .req_splat1 (req_splat1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference extension by integer arithmetic on the field value.
  function automatic logic [DW-1:0] ref_ext(input logic [17:0] imm, input logic [1:0] fmt,
                                            input logic splat);
    int                   w;
    longint               one = 1;
    longint               f;
    logic signed [DW-1:0] s;
    logic [31:0]          w32;
    logic [DW-1:0]        r;
    w = (fmt == 2'd0) ? 7 : (fmt == 2'd1) ? 10 : (fmt == 2'd2) ? 16 : 18;
    f = longint'(imm) & ((one << w) - 1);
    if (f >= (one << (w - 1))) f = f - (one << w);
    s = f;
    if (splat) begin
      w32 = s[31:0];
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = w32;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Monitor: every accepted result must match the oldest prediction.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got unexpected result %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", DW'(out_tag), DW'(e.tag));
        chk("sb_data", out_data, e.data);
      end
    end
  end

  // One cycle: drive after the edge, predict and check at the falling edge.
  task automatic step(input logic [1:0] v, input logic [17:0] i0, input logic [1:0] f0,
                      input logic s0, input logic [17:0] i1, input logic [1:0] f1,
                      input logic s1, input logic ordy);
    logic       can;
    logic       g;
    logic       w;
    logic [1:0] exp_rdy;
    @(posedge clk);
    #1;
    req_valid = v;
    req_imm0 = i0; req_fmt0 = f0; req_splat0 = s0;
    req_imm1 = i1; req_fmt1 = f1; req_splat1 = s1;
    out_ready = ordy;
    @(negedge clk);
    chk("out_valid", DW'(out_valid), DW'(m_full));
    chk("grant_cnt0", DW'(grant_cnt0), DW'(m_cnt[0]));
    chk("grant_cnt1", DW'(grant_cnt1), DW'(m_cnt[1]));
    can = !m_full || ordy;
    g = can && (v != 2'b00);
    w = (v == 2'b11) ? m_ptr : v[1];
    exp_rdy = 2'b00;
    if (g) exp_rdy[w] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    if (g) begin
      sb.push_back('{tag: w, data: w ? ref_ext(i1, f1, s1) : ref_ext(i0, f0, s0)});
      if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
      m_ptr  = ~w;
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input logic ordy);
    step(2'b00, '0, 2'd0, 1'b0, '0, 2'd0, 1'b0, ordy);
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 1'b0;
    m_cnt  = '{0, 0};
    sb.delete();
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    req_valid = 2'b11;
    out_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_cnt0", DW'(grant_cnt0), '0);
    chk("rst_cnt1", DW'(grant_cnt1), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_tag", DW'(out_tag), '0);
    model_reset();
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held from time zero, requests asserted: nothing granted.
    req_valid = 2'b11;
    out_ready = 1'b1;
    #12;
    chk("init_req_ready", DW'(req_ready), '0);
    chk("init_out_valid", DW'(out_valid), '0);
    chk("init_out_data", out_data, '0);
    req_valid = 2'b00;
    #5;
    reset = 1'b1;

    // Single even-pipe request, fmt 7 bits.
    step(2'b01, 18'h5D, 2'd0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("tp1_data", out_data, {{120{1'b1}}, 8'hDD});
    chk("tp1_tag", DW'(out_tag), '0);

    // Odd-pipe request, 18-bit splat.
    step(2'b10, '0, 2'd0, 1'b0, 18'h201AD, 2'd3, 1'b1, 1'b1);
    idle(1'b1);
    chk("tp2_data", out_data, 128'hFFFE01AD_FFFE01AD_FFFE01AD_FFFE01AD);
    chk("tp2_tag", DW'(out_tag), DW'(1));

    // Both valid: alternating grants.
    repeat (4) step(2'b11, 18'h1AA, 2'd1, 1'b0, 18'h3FF, 2'd1, 1'b0, 1'b1);

    // Hold while full and consumer stalled, then drain and grant together.
    repeat (3) begin
      step(2'b11, 18'h1AA, 2'd1, 1'b0, 18'h3FF, 2'd1, 1'b0, 1'b0);
      chk("hold_data", out_data, {DW{1'b1}});
      chk("hold_tag", DW'(out_tag), DW'(1));
    end
    step(2'b11, 18'h1AA, 2'd1, 1'b0, 18'h3FF, 2'd1, 1'b0, 1'b1);
    idle(1'b1);
    chk("nobubble_valid", DW'(out_valid), DW'(1));
    chk("nobubble_data", out_data, 128'h1AA);

    // Junk above a 16-bit field is ignored.
    step(2'b01, 18'h301DD, 2'd2, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("tp5_data", out_data, 128'h1DD);
    idle(1'b1);
    chk("drain_keep_data", out_data, 128'h1DD);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)),
           18'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           18'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end
    repeat (2) idle(1'b1);

    // Counters from zero, five even-pipe grants, then reset while full.
    async_reset();
    repeat (5) step(2'b01, 18'($urandom), 2'd1, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    idle(1'b0);
    chk("pre_rst_cnt0", DW'(grant_cnt0), DW'(5));
    chk("pre_rst_full", DW'(out_valid), DW'(1));
    async_reset();
    step(2'b11, 18'h12, 2'd0, 1'b0, 18'h34, 2'd0, 1'b0, 1'b1);
    chk("post_rst_grant0", DW'(req_ready), DW'(2'b01));
    repeat (3) idle(1'b1);
    chk("sb_empty", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
